rotate_iter: RTL and testbench



---
 rtl/rotate_iter_pkg.sv | 14 +
 rtl/rotate_iter_step.sv | 29 ++
 rtl/rotate_iter.sv | 98 +++++++++
 tb/tb_rotate_iter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/rotate_iter_pkg.sv
// Shared state encoding and direction constants for the iterative rotator.
package rotate_iter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ROT  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Direction encoding matches the upstream single-step rotator's d input.
  localparam logic ROT_RIGHT = 1'b0;
  localparam logic ROT_LEFT  = 1'b1;

endpackage

// File: rtl/rotate_iter_step.sv
// Combinational one-position rotate; with ROTATE_ITER_SHIFT_EN the vacated bit can be zero-filled.
module rotate_step
  import rotate_iter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] data,
  input  logic             dir,
`ifdef ROTATE_ITER_SHIFT_EN
  input  logic             shift,
`endif
  output logic [WIDTH-1:0] result
);

  logic w_wrap;
  logic w_fill;

  assign w_wrap = (dir == ROT_LEFT) ? data[WIDTH-1] : data[0];

`ifdef ROTATE_ITER_SHIFT_EN
  assign w_fill = shift ? 1'b0 : w_wrap;
`else
  assign w_fill = w_wrap;
`endif

  assign result = (dir == ROT_LEFT) ? {data[WIDTH-2:0], w_fill}
                                    : {w_fill, data[WIDTH-1:1]};

endmodule

// File: rtl/rotate_iter.sv
// Iterative multi-position rotator: one single-position step per clock, valid/ready on both sides.
// Optional ROTATE_ITER_SHIFT_EN adds in_shift for logical-shift operations.
module rotate_iter
  import rotate_iter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  input  logic [CNT_W-1:0] in_amt,
`ifdef ROTATE_ITER_SHIFT_EN
  input  logic             in_shift,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_data;
  logic             r_dir;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] w_step;
`ifdef ROTATE_ITER_SHIFT_EN
  logic             r_shift;
`endif

  rotate_step #(.WIDTH(WIDTH)) u_step (
    .data   (r_data),
    .dir    (r_dir),
`ifdef ROTATE_ITER_SHIFT_EN
    .shift  (r_shift),
`endif
    .result (w_step)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_data  <= '0;
      r_dir   <= ROT_RIGHT;
      r_count <= '0;
`ifdef ROTATE_ITER_SHIFT_EN
      r_shift <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && in_valid) begin
        r_data  <= in_data;
        r_dir   <= in_dir;
        r_count <= in_amt;
`ifdef ROTATE_ITER_SHIFT_EN
        r_shift <= in_shift;
`endif
      end else if (r_state == ST_ROT) begin
        r_data  <= w_step;
        r_count <= r_count - 1'b1;
      end
    end
  end

  // A zero amount skips ROT entirely so the result appears right after acceptance.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          w_next = (in_amt != '0) ? ST_ROT : ST_DONE;
      end
      ST_ROT: begin
        busy = 1'b1;
        if (r_count == CNT_W'(1))
          w_next = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready)
          w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign out_data = r_data;

endmodule

// File: tb/tb_rotate_iter.sv
// Self-checking bench for rotate_iter: directed cases plus randomized requests against an arithmetic model.
module tb_rotate_iter;
  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_dir;
  logic [1:0]   in_amt;
`ifdef ROTATE_ITER_SHIFT_EN
  logic         in_shift;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         busy;

  int checks = 0;
  int errors = 0;

  rotate_iter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dir    (in_dir),
    .in_amt    (in_amt),
`ifdef ROTATE_ITER_SHIFT_EN
    .in_shift  (in_shift),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: whole-word rotate/shift by amt using plain integer arithmetic.
  function automatic logic [W-1:0] modelResult(input int d, input logic dir, input int amt,
                                               input logic sh);
    int mask;
    int v;
    mask = (1 << W) - 1;
    if (sh)
      v = dir ? ((d << amt) & mask) : (d >> amt);
    else if (dir)
      v = ((d << amt) | (d >> (W - amt))) & mask;
    else
      v = ((d >> amt) | (d << (W - amt))) & mask;
    return v[W-1:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drives one full request from acceptance to transfer, checking every cycle on negedges.
  task automatic applyStimulus(input logic [W-1:0] d, input logic dir, input int amt,
                               input logic sh, input int hold);
    logic [W-1:0] exp;
    int guard;
    exp = modelResult(int'(d), dir, amt, sh);
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("readyBeforeRequest", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_dir   = dir;
    in_amt   = 2'(amt);
`ifdef ROTATE_ITER_SHIFT_EN
    in_shift = sh;
`endif
    @(posedge clk);
    #1;
    in_data = W'($urandom);
    in_dir  = 1'($urandom);
    in_amt  = 2'($urandom);
    for (int k = 0; k <= amt; k++) begin
      @(negedge clk);
      checkOutput("outValidTiming", {31'd0, out_valid}, {31'd0, k == amt});
      checkOutput("inReadyBusy", {31'd0, in_ready}, 32'd0);
      checkOutput("busyHigh", {31'd0, busy}, 32'd1);
      if (k < amt) begin
        out_ready = 1'($urandom);
        in_valid  = 1'($urandom);
      end else begin
        in_valid  = 1'b0;
        out_ready = (hold == 0);
      end
    end
    checkOutput("resultData", {28'd0, out_data}, {28'd0, exp});
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checkOutput("holdValid", {31'd0, out_valid}, 32'd1);
      checkOutput("holdData", {28'd0, out_data}, {28'd0, exp});
      checkOutput("holdReadyLow", {31'd0, in_ready}, 32'd0);
      out_ready = (h == hold - 1);
    end
    @(negedge clk);
    checkOutput("afterTransferReady", {31'd0, in_ready}, 32'd1);
    checkOutput("afterTransferValid", {31'd0, out_valid}, 32'd0);
    checkOutput("afterTransferBusy", {31'd0, busy}, 32'd0);
    out_ready = 1'($urandom);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_dir    = 1'b0;
    in_amt    = '0;
    out_ready = 1'b0;
`ifdef ROTATE_ITER_SHIFT_EN
    in_shift  = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("resetReady", {31'd0, in_ready}, 32'd1);
    checkOutput("resetValid", {31'd0, out_valid}, 32'd0);
    checkOutput("resetBusy", {31'd0, busy}, 32'd0);
    checkOutput("resetData", {28'd0, out_data}, 32'd0);
    rst = 1'b0;

    applyStimulus(4'b1100, 1'b0, 1, 1'b0, 0);
    applyStimulus(4'b0110, 1'b1, 1, 1'b0, 0);
    applyStimulus(4'b1001, 1'b1, 3, 1'b0, 1);
    applyStimulus(4'b1010, 1'b0, 0, 1'b0, 2);
    applyStimulus(4'b0111, 1'b0, 2, 1'b0, 5);

    // Reset while rotating must discard the operation entirely.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 4'b0001;
    in_dir   = 1'b1;
    in_amt   = 2'd3;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("preResetBusy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b0;
    checkOutput("midResetReady", {31'd0, in_ready}, 32'd1);
    checkOutput("midResetValid", {31'd0, out_valid}, 32'd0);
    checkOutput("midResetData", {28'd0, out_data}, 32'd0);
    checkOutput("midResetBusy", {31'd0, busy}, 32'd0);
    applyStimulus(4'b0001, 1'b1, 3, 1'b0, 0);

`ifdef ROTATE_ITER_SHIFT_EN
    applyStimulus(4'b1100, 1'b0, 2, 1'b1, 0);
    applyStimulus(4'b1011, 1'b1, 1, 1'b1, 1);
`endif

    for (int n = 0; n < 40; n++) begin
      logic sh;
      sh = 1'b0;
`ifdef ROTATE_ITER_SHIFT_EN
      sh = 1'($urandom);
`endif
      applyStimulus(W'($urandom), 1'($urandom), int'($urandom_range(0, 3)), sh,
                    int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
